uart_rx_oversample: RTL

//  Serial receive end of the on-board 9600-baud 8N1 link: the receiver counterpart of the parallel-load transmitter.

---
 rtl/uart_rx_oversample.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   Receive side of the 9600-baud 8N1 board link. The line is sampled at
//   16x the bit rate from the system clock. A start bit must still be low at
//   its middle or it is treated as a glitch. Each bit is the majority of
//   three mid-bit samples. The stop bit is checked at its middle and the byte
//   is then held in a one-deep buffer with a valid/ack handshake.
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx_serial  asynchronous serial line, idle high
//   rd_ack     consumer acknowledge; pops the buffer while rx_valid is high
//   rx_data    last accepted byte
//   rx_valid   buffer holds an unread byte
//   frame_err  one-clock pulse when a stop bit is sampled low
//   overrun    sticky; a frame completed while the buffer was still full
//   busy       receiver is not idle
module uart_rx_oversample #(
  parameter int CLKS_PER_SAMPLE = 326,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_SAMPLE - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 sync1_r, rxs_r;
  logic [TW-1:0]        tick_cnt_r;
  logic                 tick_s;
  state_t               state_r, state_n;
  logic [3:0]           sc_r, sc_n;
  logic [IW-1:0]        bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 samp7_r, samp7_n, samp8_r, samp8_n;
  logic                 maj_s, accept_s, ferr_s;
  logic [DATA_BITS-1:0] rx_data_r, rx_data_n;
  logic                 rx_valid_r, rx_valid_n;
  logic                 overrun_r, overrun_n;
  logic                 frame_err_r, busy_r;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  // Sample 9 is taken live from rxs_r on the deciding tick; 7 and 8 were stored earlier.
  assign maj_s     = majority3(samp7_r, samp8_r, rxs_r);

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

  // Line synchronizer and free-running 16x sample tick generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      tick_cnt_r <= '0;
    end else begin
      sync1_r    <= rx_serial;
      rxs_r      <= sync1_r;
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
    end
  end

  // Frame FSM next state, mid-bit sampling and data shifting (tick cycles only).
  always_comb begin
    state_n   = state_r;
    sc_n      = sc_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    samp7_n   = samp7_r;
    samp8_n   = samp8_r;
    accept_s  = 1'b0;
    ferr_s    = 1'b0;
    if (tick_s && (sc_r == 4'd7)) begin
      samp7_n = rxs_r;
    end else begin
      samp7_n = samp7_r;
    end
    if (tick_s && (sc_r == 4'd8)) begin
      samp8_n = rxs_r;
    end else begin
      samp8_n = samp8_r;
    end
    if (tick_s) begin
      case (state_r)
        S_IDLE: begin
          if (!rxs_r) begin
            state_n = S_START;
            sc_n    = 4'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_START: begin
          sc_n = sc_r + 4'd1;
          if ((sc_r == 4'd9) && maj_s) begin
            state_n = S_IDLE;          // line back high mid-start: glitch
          end else if (sc_r == 4'd15) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = S_START;
          end
        end
        S_DATA: begin
          sc_n = sc_r + 4'd1;            // 15 wraps to 0 for the next bit
          if (sc_r == 4'd9) begin
            shift_n = {maj_s, shift_r[DATA_BITS-1:1]};
          end else if (sc_r == 4'd15) begin
            if (bit_idx_r == BIT_LAST) begin
              state_n = S_STOP;
            end else begin
              bit_idx_n = bit_idx_r + IW'(1);
            end
          end else begin
            shift_n = shift_r;
          end
        end
        S_STOP: begin
          sc_n = sc_r + 4'd1;
          if (sc_r == 4'd9) begin
            if (maj_s) begin
              accept_s = 1'b1;
              state_n  = S_IDLE;
            end else begin
              ferr_s   = 1'b1;
              state_n  = S_BREAK;
            end
          end else begin
            state_n = S_STOP;
          end
        end
        S_BREAK: begin
          // Wait for the line to return high so a held-low line is not a new start.
          if (rxs_r) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_BREAK;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // One-deep receive buffer with valid/ack handshake and sticky overrun.
  always_comb begin
    rx_data_n  = rx_data_r;
    rx_valid_n = rx_valid_r;
    overrun_n  = overrun_r;
    if (accept_s) begin
      // An ack on the accept edge frees the slot for the new byte.
      if (!rx_valid_r || rd_ack) begin
        rx_data_n  = shift_r;
        rx_valid_n = 1'b1;
        overrun_n  = 1'b0;
      end else begin
        overrun_n  = 1'b1;
      end
    end else if (rd_ack && rx_valid_r) begin
      rx_valid_n = 1'b0;
      overrun_n  = 1'b0;
    end else begin
      rx_valid_n = rx_valid_r;
    end
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      sc_r        <= 4'd0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      samp7_r     <= 1'b0;
      samp8_r     <= 1'b0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      sc_r        <= sc_n;
      bit_idx_r   <= bit_idx_n;
      shift_r     <= shift_n;
      samp7_r     <= samp7_n;
      samp8_r     <= samp8_n;
      rx_data_r   <= rx_data_n;
      rx_valid_r  <= rx_valid_n;
      overrun_r   <= overrun_n;
      frame_err_r <= ferr_s;
      busy_r      <= (state_n != S_IDLE);
    end
  end

endmodule
